// File: rtl/sram_burst_initiator_pkg.sv
// Shared types for the sram burst initiator: FSM state encoding, request
// opcode and the beat-counter width helper.
package sram_burst_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BEAT  = 3'd1,
    WR_DONE  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_HOLD  = 3'd5
  } init_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Beat counter width; a single-word burst still needs a 1-bit counter.
  function automatic int beat_w(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/sram_burst_initiator_if.sv
// Client-side bundle of the burst initiator: request, write-beat and
// read-beat handshakes. The cache controller is the master.
interface sram_burst_initiator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_done;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  modport master (
    output req_valid, req_we, req_addr, wr_valid, wr_data, rd_ready,
    input  req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_valid, wr_data, rd_ready,
    output req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/sram_burst_initiator.sv
// Burst initiator for a single-port sram: converts cache line fill /
// writeback requests into one sram access per word. Every client and
// sram output comes straight from a flop.
module sram_burst_initiator
  import sram_burst_initiator_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int BURST        = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_burst_initiator_if.slave client,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int BW = beat_w(BURST);
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BURST - 1);
  localparam logic [BW-1:0]         BEAT_MAX = BW'(BURST - 1);
  localparam logic [LW-1:0]         LAT_MAX  = LW'(READ_LATENCY - 1);

  init_state_e           state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BW-1:0]         beat_q;
  logic [LW-1:0]         lat_q;
  logic                  req_ready_q, wr_ready_q, wr_done_q;
  logic                  rd_valid_q, rd_last_q, busy_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_re_q, mem_we_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  op_e                   req_op_d;
  logic [ADDR_WIDTH-1:0] req_base_d;
  logic [BW-1:0]         beat_d;
  logic                  beat_last_d;

  // Request decode and beat bookkeeping shared by the read and write paths.
  always_comb begin
    req_op_d    = client.req_we ? OP_WR : OP_RD;
    req_base_d  = client.req_addr & ~OFF_MASK;
    beat_d      = beat_q + BW'(1);
    beat_last_d = (beat_q == BEAT_MAX);
  end

  // Burst FSM; sram strobes and wr_done default low so each is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (client.req_valid) begin
            base_q      <= req_base_d;
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_op_d == OP_WR) begin
              state_q    <= WR_BEAT;
              wr_ready_q <= 1'b1;
            end else begin
              // First read strobe is raised on entry so RD_ISSUE carries it.
              state_q    <= RD_ISSUE;
              mem_re_q   <= 1'b1;
              mem_addr_q <= req_base_d;
            end
          end
        end
        WR_BEAT: begin
          if (client.wr_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= base_q + ADDR_WIDTH'(beat_q);
            mem_wdata_q <= client.wr_data;
            beat_q      <= beat_d;
            if (beat_last_d) begin
              state_q    <= WR_DONE;
              wr_ready_q <= 1'b0;
              wr_done_q  <= 1'b1;
            end
          end
        end
        WR_DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        RD_ISSUE: begin
          state_q <= RD_WAIT;
          lat_q   <= '0;
        end
        RD_WAIT: begin
          // lat_q counts cycles since the sram sampled mem_re.
          if (lat_q == LAT_MAX) begin
            rd_data_q  <= mem_rdata_i;
            rd_valid_q <= 1'b1;
            rd_last_q  <= beat_last_d;
            state_q    <= RD_HOLD;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        RD_HOLD: begin
          if (client.rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            beat_q     <= beat_d;
            if (beat_last_d) begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q    <= RD_ISSUE;
              mem_re_q   <= 1'b1;
              mem_addr_q <= base_q + ADDR_WIDTH'(beat_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign client.req_ready = req_ready_q;
  assign client.wr_ready  = wr_ready_q;
  assign client.wr_done   = wr_done_q;
  assign client.rd_valid  = rd_valid_q;
  assign client.rd_data   = rd_data_q;
  assign client.rd_last   = rd_last_q;
  assign busy_o           = busy_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_re_o         = mem_re_q;
  assign mem_we_o         = mem_we_q;
  assign mem_wdata_o      = mem_wdata_q;

endmodule

// File: tb/tb_sram_burst_initiator.sv
// Directed bench for sram_burst_initiator with a behavioural 16-word sram
// (read latency 1) attached to the memory side.
module tb_sram_burst_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy, mem_re, mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sram_burst_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  sram_burst_initiator #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BURST(4), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .client(bus), .busy_o(busy),
    .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Behavioural sram: preloaded with A5A5_00nn on the first edge, 1-cycle read.
  logic [31:0] sram [16];
  bit          sram_init = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sram_init) begin
      for (int i = 0; i < 16; i++) sram[i] <= 32'hA5A5_0000 + i;
      sram_init <= 1'b1;
    end else begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr];
    end
  end

  // Bus monitor sampled on the falling edge.
  int          we_cyc[$];
  logic [3:0]  we_addr[$];
  logic [31:0] we_data[$];
  logic [3:0]  re_addr[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          overlap_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cyc.push_back(cyc);
      we_addr.push_back(mem_addr);
      we_data.push_back(mem_wdata);
    end
    if (mem_re) re_addr.push_back(mem_addr);
    if (bus.wr_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (mem_we && mem_re) overlap_cnt <= overlap_cnt + 1;
  end

  logic [31:0] rd_got_data [4];
  logic        rd_got_last [4];
  int          rd_got_n;

  // Issue one request and return at the falling edge after its handshake.
  task automatic send_req(input logic we, input logic [3:0] addr);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL req_handshake_timeout: req_ready=%b required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Collect up to four read beats (rd_ready driven by caller), bounded.
  task automatic collect_reads();
    int n = 0;
    rd_got_n = 0;
    while (rd_got_n < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.rd_valid && bus.rd_ready) begin
        rd_got_data[rd_got_n] = bus.rd_data;
        rd_got_last[rd_got_n] = bus.rd_last;
        rd_got_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.req_ready, bus.wr_ready, bus.wr_done, bus.rd_valid, bus.rd_last, busy, mem_re, mem_we} !== 8'b1000_0000) begin
      fails++;
      $display("FAIL reset_flags: got %b required 10000000",
               {bus.req_ready, bus.wr_ready, bus.wr_done, bus.rd_valid, bus.rd_last, busy, mem_re, mem_we});
    end
    tests++;
    if (mem_addr !== 4'h0 || mem_wdata !== 32'h0 || bus.rd_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h rd_data=%h required all 0", mem_addr, mem_wdata, bus.rd_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: req_ready=%b busy=%b required 1/0", bus.req_ready, busy);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_write_burst();
    int b0 = we_addr.size();
    int d0 = done_cnt;
    send_req(1'b1, 4'h4);
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'hDEADBEEF + i;
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (we_addr.size() - b0 != 4) begin
      fails++;
      $display("FAIL wr_beat_count: got %0d required 4", we_addr.size() - b0);
    end
    for (int i = 0; i < 4; i++) begin
      if (we_addr.size() > b0 + i) begin
        tests++;
        if (we_addr[b0+i] !== 4'(4 + i) || we_data[b0+i] !== 32'hDEADBEEF + i) begin
          fails++;
          $display("FAIL wr_beat%0d: addr=%h data=%h required %h/%h", i, we_addr[b0+i], we_data[b0+i], 4'(4 + i), 32'hDEADBEEF + i);
        end
        if (i > 0) begin
          tests++;
          if (we_cyc[b0+i] - we_cyc[b0+i-1] != 1) begin
            fails++;
            $display("FAIL wr_back_to_back%0d: gap=%0d required 1", i, we_cyc[b0+i] - we_cyc[b0+i-1]);
          end
        end
      end
    end
    tests++;
    if (done_cnt - d0 != 1 || we_addr.size() < b0 + 4 || done_cyc != we_cyc[b0+3]) begin
      fails++;
      $display("FAIL wr_done_pulse: count=%0d cycle=%0d required 1 pulse with last mem_we", done_cnt - d0, done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (sram[4+i] !== 32'hDEADBEEF + i) begin
        fails++;
        $display("FAIL wr_sram_word%0d: got %h required %h", 4 + i, sram[4+i], 32'hDEADBEEF + i);
      end
    end
    $display("[TB] write burst base 4: %0d mem_we beats", we_addr.size() - b0);
  endtask

  task automatic test_read_burst();
    int r0 = re_addr.size();
    int o0 = overlap_cnt;
    bus.rd_ready = 1'b1;
    send_req(1'b0, 4'h4);
    collect_reads();
    repeat (2) @(negedge clk);
    tests++;
    if (rd_got_n != 4) begin
      fails++;
      $display("FAIL rd_beat_count: got %0d required 4", rd_got_n);
    end
    for (int i = 0; i < rd_got_n; i++) begin
      tests++;
      if (rd_got_data[i] !== 32'hDEADBEEF + i || rd_got_last[i] !== (i == 3)) begin
        fails++;
        $display("FAIL rd_beat%0d: data=%h last=%b required %h/%b", i, rd_got_data[i], rd_got_last[i], 32'hDEADBEEF + i, (i == 3));
      end
    end
    tests++;
    if (re_addr.size() - r0 != 4 || overlap_cnt != o0) begin
      fails++;
      $display("FAIL rd_strobes: mem_re=%0d overlap=%0d required 4/0", re_addr.size() - r0, overlap_cnt - o0);
    end
    for (int i = 0; i < 4 && r0 + i < re_addr.size(); i++) begin
      tests++;
      if (re_addr[r0+i] !== 4'(4 + i)) begin
        fails++;
        $display("FAIL rd_addr%0d: got %h required %h", i, re_addr[r0+i], 4'(4 + i));
      end
    end
    tests++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rd_back_to_idle: req_ready=%b busy=%b required 1/0", bus.req_ready, busy);
    end
    $display("[TB] read burst base 4: %0d beats", rd_got_n);
  endtask

  task automatic test_unaligned();
    int r0 = re_addr.size();
    bus.rd_ready = 1'b1;
    send_req(1'b0, 4'hB);
    collect_reads();
    repeat (2) @(negedge clk);
    tests++;
    if (re_addr.size() - r0 != 4 || rd_got_n != 4) begin
      fails++;
      $display("FAIL unaligned_count: mem_re=%0d beats=%0d required 4/4", re_addr.size() - r0, rd_got_n);
    end
    for (int i = 0; i < 4 && r0 + i < re_addr.size() && i < rd_got_n; i++) begin
      tests++;
      if (re_addr[r0+i] !== 4'(8 + i) || rd_got_data[i] !== 32'hA5A5_0008 + i) begin
        fails++;
        $display("FAIL unaligned_beat%0d: addr=%h data=%h required %h/%h", i, re_addr[r0+i], rd_got_data[i], 4'(8 + i), 32'hA5A5_0008 + i);
      end
    end
    $display("[TB] unaligned read 0xB: %0d beats", rd_got_n);
  endtask

  task automatic test_read_stall();
    int r0 = re_addr.size();
    int idx = 0;
    int n = 0;
    bit stalled = 1'b0;
    bus.rd_ready = 1'b1;
    send_req(1'b0, 4'h0);
    while (idx < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.rd_valid) begin
        if (idx == 1 && !stalled) begin
          stalled = 1'b1;
          bus.rd_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n++;
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hA5A5_0001 || re_addr.size() - r0 != 2) begin
              fails++;
              $display("FAIL rd_stall_hold%0d: valid=%b data=%h mem_re=%0d required 1/a5a50001/2", k, bus.rd_valid, bus.rd_data, re_addr.size() - r0);
            end
          end
          bus.rd_ready = 1'b1;
        end
        tests++;
        if (bus.rd_data !== 32'hA5A5_0000 + idx || bus.rd_last !== (idx == 3)) begin
          fails++;
          $display("FAIL rd_stall_beat%0d: data=%h last=%b required %h/%b", idx, bus.rd_data, bus.rd_last, 32'hA5A5_0000 + idx, (idx == 3));
        end
        idx++;
      end
    end
    repeat (2) @(negedge clk);
    tests++;
    if (idx != 4 || re_addr.size() - r0 != 4) begin
      fails++;
      $display("FAIL rd_stall_total: beats=%0d mem_re=%0d required 4/4", idx, re_addr.size() - r0);
    end
    $display("[TB] read with 5-cycle stall on beat 1: %0d beats", idx);
  endtask

  task automatic test_write_gaps();
    int b0 = we_addr.size();
    int d0 = done_cnt;
    int gap_req [4] = '{0, 1, 4, 1};
    send_req(1'b1, 4'hC);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.wr_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h1234_0000 + i;
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (we_addr.size() - b0 != 4 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL gap_counts: mem_we=%0d wr_done=%0d required 4/1", we_addr.size() - b0, done_cnt - d0);
    end
    for (int i = 0; i < 4 && b0 + i < we_addr.size(); i++) begin
      tests++;
      if (we_addr[b0+i] !== 4'(12 + i) || sram[12+i] !== 32'h1234_0000 + i) begin
        fails++;
        $display("FAIL gap_beat%0d: addr=%h sram=%h required %h/%h", i, we_addr[b0+i], sram[12+i], 4'(12 + i), 32'h1234_0000 + i);
      end
      if (i > 0) begin
        tests++;
        if (we_cyc[b0+i] - we_cyc[b0+i-1] != gap_req[i]) begin
          fails++;
          $display("FAIL gap_spacing%0d: got %0d required %0d", i, we_cyc[b0+i] - we_cyc[b0+i-1], gap_req[i]);
        end
      end
    end
    $display("[TB] write with gap before beat 2: %0d mem_we beats", we_addr.size() - b0);
  endtask

  task automatic test_reset_mid_write();
    int b0 = we_addr.size();
    int d0 = done_cnt;
    logic [31:0] exp_rd [4] = '{32'h5555_0000, 32'h5555_0001, 32'hA5A5_0002, 32'hA5A5_0003};
    send_req(1'b1, 4'h0);
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h5555_0000 + i;
      @(negedge clk);
    end
    rst = 1'b1;
    bus.wr_data = 32'h5555_0002;
    @(negedge clk);
    tests++;
    if ({bus.req_ready, bus.wr_ready, bus.wr_done, bus.rd_valid, bus.rd_last, busy, mem_re, mem_we} !== 8'b1000_0000
        || mem_addr !== 4'h0 || mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs: flags=%b addr=%h wdata=%h required 10000000/0/0",
               {bus.req_ready, bus.wr_ready, bus.wr_done, bus.rd_valid, bus.rd_last, busy, mem_re, mem_we}, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (we_addr.size() - b0 != 2 || done_cnt != d0) begin
      fails++;
      $display("FAIL mid_reset_abandon: mem_we=%0d wr_done=%0d required 2/0", we_addr.size() - b0, done_cnt - d0);
    end
    bus.rd_ready = 1'b1;
    send_req(1'b0, 4'h0);
    collect_reads();
    tests++;
    if (rd_got_n != 4) begin
      fails++;
      $display("FAIL mid_reset_readback_count: got %0d required 4", rd_got_n);
    end
    for (int i = 0; i < rd_got_n; i++) begin
      tests++;
      if (rd_got_data[i] !== exp_rd[i]) begin
        fails++;
        $display("FAIL mid_reset_readback%0d: got %h required %h", i, rd_got_data[i], exp_rd[i]);
      end
    end
    $display("[TB] reset mid write burst, readback %0d beats", rd_got_n);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_unaligned();
    test_read_stall();
    test_write_gaps();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
